// File: rtl/pld_prog_pkg.sv
// pld_pkg: shared types and configuration-layout helpers for the
// programmable PLA (pld_prog). The index helpers are the single source of
// truth for where each AND-plane literal and OR-plane/invert bit lives in
// the serial configuration image.
package pld_pkg;

  localparam int N_IN_D   = 6;
  localparam int N_TERM_D = 8;
  localparam int N_OUT_D  = 5;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Total configuration bits: AND plane (true + complement literal per
  // input per term), then per output N_TERM OR selects plus one invert bit.
  function automatic int cfg_bits(input int n_in, input int n_term, input int n_out);
    return n_term*2*n_in + n_out*(n_term+1);
  endfunction

  // AND-plane bit for term t, input i; neg=0 selects din[i], neg=1 ~din[i].
  function automatic int and_idx(input int t, input int i, input int neg,
                                 input int n_in = N_IN_D);
    return t*2*n_in + 2*i + neg;
  endfunction

  // First OR-select bit of output o; its invert bit sits at base+n_term.
  function automatic int or_base(input int o, input int n_in, input int n_term);
    return n_term*2*n_in + o*(n_term+1);
  endfunction

endpackage

// File: rtl/pld_prog_if.sv
// pld_prog_if: configuration handshake plus evaluation bus of pld_prog.
//   master (driver side): cfg_start, cfg_valid, cfg_bit, in_valid, din out;
//                         cfg_ready, cfg_done, dout, dout_valid in.
//   slave  (pld_prog)   : the mirror image.
interface pld_prog_if #(
  parameter int N_IN  = 6,
  parameter int N_OUT = 5
);
  logic             cfg_start;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_ready;
  logic             cfg_done;
  logic             in_valid;
  logic [N_IN-1:0]  din;
  logic [N_OUT-1:0] dout;
  logic             dout_valid;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, din,
    input  cfg_ready, cfg_done, dout, dout_valid
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, din,
    output cfg_ready, cfg_done, dout, dout_valid
  );
endinterface

// File: rtl/pld_prog_and_plane.sv
// pld_and_plane: combinational AND plane of the PLA.
//   din     : logic inputs
//   and_cfg : AND-plane configuration (2 select bits per input per term)
//   term    : product-term vector
// A term with no literal selected is treated as unprogrammed and yields 0.
// Selecting both polarities of one input makes the term unsatisfiable (0).
module pld_and_plane
  import pld_pkg::*;
#(
  parameter int N_IN   = 6,
  parameter int N_TERM = 8
) (
  input  logic [N_IN-1:0]          din,
  input  logic [N_TERM*2*N_IN-1:0] and_cfg,
  output logic [N_TERM-1:0]        term
);

  for (genvar t = 0; t < N_TERM; t++) begin : g_term
    logic [N_IN-1:0] lit_ok;
    logic [N_IN-1:0] any_sel;

    for (genvar i = 0; i < N_IN; i++) begin : g_lit
      localparam int IP = and_idx(t, i, 0, N_IN);
      localparam int IN = and_idx(t, i, 1, N_IN);
      // An unselected literal never blocks the product.
      assign lit_ok[i]  = (~and_cfg[IP] | din[i]) & (~and_cfg[IN] | ~din[i]);
      assign any_sel[i] = and_cfg[IP] | and_cfg[IN];
    end

    assign term[t] = (|any_sel) & (&lit_ok);
  end

endmodule

// File: rtl/pld_prog.sv
// pld_prog: field-programmable sum-of-products PLA with registered outputs.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : pld_prog_if.slave
//     cfg_start/cfg_valid/cfg_bit/cfg_ready : serial config load handshake
//     cfg_done                              : complete config active (RUN)
//     in_valid/din                          : evaluation request
//     dout/dout_valid                       : registered result, 1-cycle pulse
// Config is shifted in LSB-first at the bit counter; the FSM leaves LOAD on
// the cycle the last bit is accepted, so cfg_done rises one cycle later.
module pld_prog
  import pld_pkg::*;
#(
  parameter int N_IN   = 6,
  parameter int N_TERM = 8,
  parameter int N_OUT  = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  pld_prog_if.slave bus
);

  localparam int CFG_BITS = cfg_bits(N_IN, N_TERM, N_OUT);
  localparam int AND_BITS = N_TERM*2*N_IN;
  localparam int CNT_W    = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS-1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [N_OUT-1:0]    dout_q, dout_d;
  logic                dv_q, dv_d;

  logic [N_TERM-1:0]   term;
  logic [N_OUT-1:0]    eval;

  pld_and_plane #(
    .N_IN  (N_IN),
    .N_TERM(N_TERM)
  ) u_and (
    .din    (bus.din),
    .and_cfg(cfg_q[AND_BITS-1:0]),
    .term   (term)
  );

  // OR plane + per-output invert; an output with no terms selected gives
  // just its invert bit.
  for (genvar o = 0; o < N_OUT; o++) begin : g_or
    localparam int B = or_base(o, N_IN, N_TERM);
    assign eval[o] = (|(term & cfg_q[B +: N_TERM])) ^ cfg_q[B+N_TERM];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    unique case (state_q)
      UNCFG: begin
        if (bus.cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          dout_d  = '0;
        end
      end
      LOAD: begin
        // start beats a coincident bit: the bit is dropped, counter rewinds
        if (bus.cfg_start) begin
          cnt_d = '0;
        end else if (bus.cfg_valid) begin
          cfg_d[cnt_q] = bus.cfg_bit;
          if (cnt_q == CNT_LAST) state_d = RUN;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // start beats a coincident evaluation: no dout_valid
        if (bus.cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
          dout_d  = '0;
        end else if (bus.in_valid) begin
          dout_d = eval;
          dv_d   = 1'b1;
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNCFG;
      cnt_q   <= '0;
      cfg_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end

  assign bus.cfg_ready  = (state_q == LOAD);
  assign bus.cfg_done   = (state_q == RUN);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;

endmodule
